iso14443a_miller_rx: RTL and testbench

Receive-side modified-Miller decoder for the ISO/IEC 14443-A 106 kbit/s PCD→PICC link. It sits between the `miller_in` pad and the ISO14443 framing/control logic. It oversamples the demodulated pause signal with the 13.56 MHz card clock and recovers SOF, data bits, parity and EOF. It delivers one character per pulse, plus frame markers, to the downstream frame handler.

---
 rtl/iso14443a_miller_rx.sv | 194 +++++++++++++++++++
 tb/tb_iso14443a_miller_rx.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iso14443a_miller_rx.sv
// Modified-Miller receive decoder for the ISO/IEC 14443-A 106 kbit/s PCD->PICC link.
// Oversamples the pause signal per etu and recovers SOF, data bits, parity and EOF.
module iso14443a_miller_rx #(
  parameter int unsigned BIT_CLKS   = 128,
  parameter bit          PARITY_ODD = 1'b1
) (
  input  logic       clk_sc,
  input  logic       resetn,
  input  logic       rx_en,
  input  logic       miller_in,
  output logic [7:0] rx_data,
  output logic [3:0] rx_nbits,
  output logic       rx_valid,
  output logic       rx_par_err,
  output logic       rx_sof,
  output logic       rx_eof,
  output logic       rx_err,
  output logic       rx_busy
);

  localparam int unsigned CntW = $clog2(BIT_CLKS);
  localparam logic [CntW-1:0] SampQ1 = CntW'(BIT_CLKS / 4);
  localparam logic [CntW-1:0] SampQ3 = CntW'(3 * BIT_CLKS / 4);
  localparam logic [CntW-1:0] WinEnd = CntW'(BIT_CLKS - 1);

  typedef enum logic [1:0] {StIdle, StSof, StData} state_e;
  state_e state_q, state_d;

  logic            m_meta_q, m_s_q, m_prev_q;
  logic [CntW-1:0] bcnt_q, bcnt_d;
  logic            s1_q, s1_d, s3_q, s3_d;
  logic            prev_q, prev_d, pend_q, pend_d, pend_bit_q, pend_bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic [3:0]      nbits_q, nbits_d;
  logic            valid_q, valid_d, par_q, par_d, sof_q, sof_d;
  logic            eof_q, eof_d, err_q, err_d, busy_q, busy_d;

  logic fall, win_end, sym_z, sym_x, sym_y, sym_bad, eof_sym, code_err;

  always_ff @(posedge clk_sc or negedge resetn) begin
    if (!resetn) begin
      m_meta_q <= 1'b1;
      m_s_q    <= 1'b1;
      m_prev_q <= 1'b1;
    end else begin
      m_meta_q <= miller_in;
      m_s_q    <= m_meta_q;
      m_prev_q <= m_s_q;
    end
  end

  assign fall     = m_prev_q & ~m_s_q;
  assign win_end  = (bcnt_q == WinEnd);
  assign sym_z    = ~s1_q & s3_q;
  assign sym_x    = s1_q & ~s3_q;
  assign sym_y    = s1_q & s3_q;
  assign sym_bad  = ~s1_q & ~s3_q;
  assign eof_sym  = sym_y & ~prev_q;
  // A Y right after SOF has nothing pending: empty frame, treated as a coding error.
  assign code_err = sym_bad | (sym_z & prev_q) | (eof_sym & ~pend_q);

  always_ff @(posedge clk_sc or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (rx_en && fall) state_d = StSof;
      StSof: begin
        if (!rx_en) state_d = StIdle;
        else if (win_end) state_d = sym_z ? StData : StIdle;
      end
      StData: begin
        if (!rx_en) state_d = StIdle;
        else if (win_end && (eof_sym || code_err)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bcnt_d     = win_end ? '0 : bcnt_q + CntW'(1);
    s1_d       = (bcnt_q == SampQ1) ? m_s_q : s1_q;
    s3_d       = (bcnt_q == SampQ3) ? m_s_q : s3_q;
    prev_d     = prev_q;
    pend_d     = pend_q;
    pend_bit_d = pend_bit_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    nbits_d    = nbits_q;
    par_d      = par_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    err_d      = 1'b0;
    busy_d     = (state_d != StIdle);
    if (state_q == StIdle) bcnt_d = '0;
    if (rx_en && win_end) begin
      if (state_q == StSof && sym_z) begin
        sof_d   = 1'b1;
        prev_d  = 1'b0;
        pend_d  = 1'b0;
        shift_d = '0;
        cnt_d   = '0;
      end else if (state_q == StData) begin
        if (code_err) begin
          err_d = 1'b1;
        end else if (eof_sym) begin
          // The pending 0 opens the EOF sequence and is dropped.
          eof_d = 1'b1;
          if (cnt_q != 4'd0) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            nbits_d = cnt_q;
            par_d   = 1'b0;
          end
        end else begin
          prev_d     = sym_x;
          pend_bit_d = sym_x;
          pend_d     = 1'b1;
          if (pend_q) begin
            if (cnt_q == 4'd8) begin
              valid_d = 1'b1;
              data_d  = shift_q;
              nbits_d = 4'd8;
              par_d   = ((^shift_q) ^ pend_bit_q) != PARITY_ODD;
              shift_d = '0;
              cnt_d   = '0;
            end else begin
              shift_d[cnt_q[2:0]] = pend_bit_q;
              cnt_d               = cnt_q + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_sc or negedge resetn) begin
    if (!resetn) begin
      bcnt_q     <= '0;
      s1_q       <= 1'b1;
      s3_q       <= 1'b1;
      prev_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_bit_q <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      nbits_q    <= '0;
      par_q      <= 1'b0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      bcnt_q     <= bcnt_d;
      s1_q       <= s1_d;
      s3_q       <= s3_d;
      prev_q     <= prev_d;
      pend_q     <= pend_d;
      pend_bit_q <= pend_bit_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      nbits_q    <= nbits_d;
      par_q      <= par_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_nbits   = nbits_q;
  assign rx_valid   = valid_q;
  assign rx_par_err = par_q;
  assign rx_sof     = sof_q;
  assign rx_eof     = eof_q;
  assign rx_err     = err_q;
  assign rx_busy    = busy_q;

endmodule

// File: tb/tb_iso14443a_miller_rx.sv
// Randomised bench for iso14443a_miller_rx: frames are built as bit lists, Miller-encoded onto the
// pad, and every output is checked each cycle against events predicted from the bit list.
module tb_iso14443a_miller_rx;

  localparam int BC      = 128;
  localparam bit PAR_ODD = 1'b1;
  localparam int SZ = 0, SX = 1, SY = 2, SB = 3;

  logic       clk_sc = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_en = 1'b0;
  logic       miller_in = 1'b1;
  logic [7:0] rx_data;
  logic [3:0] rx_nbits;
  logic       rx_valid, rx_par_err, rx_sof, rx_eof, rx_err, rx_busy;

  iso14443a_miller_rx #(
    .BIT_CLKS  (BC),
    .PARITY_ODD(PAR_ODD)
  ) dut (
    .clk_sc    (clk_sc),
    .resetn    (resetn),
    .rx_en     (rx_en),
    .miller_in (miller_in),
    .rx_data   (rx_data),
    .rx_nbits  (rx_nbits),
    .rx_valid  (rx_valid),
    .rx_par_err(rx_par_err),
    .rx_sof    (rx_sof),
    .rx_eof    (rx_eof),
    .rx_err    (rx_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk_sc = ~clk_sc;

  int cyc = 0;
  always @(posedge clk_sc) cyc <= cyc + 1;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic       err;
    logic       valid;
    logic [7:0] data;
    logic [3:0] nbits;
    logic       par;
  } ev_t;

  ev_t        ev[int];
  int         busy_lo = 0, busy_hi = 0;
  logic [7:0] m_data = '0;
  logic [3:0] m_nbits = '0;
  logic       m_par = 1'b0;
  int         n_cmp = 0, n_bad = 0;
  bit         fb[$];

  int         sof_cyc, eof_cyc;
  logic [7:0] cap_d[$];
  logic [3:0] cap_n[$];
  logic       cap_p[$];
  int         cap_c[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void add_ev(input int t, input ev_t e);
    ev_t o;
    o = ev.exists(t) ? ev[t] : '0;
    ev[t] = o | e;
  endfunction

  // Per-cycle scoreboard: pulses must appear exactly where predicted, payload holds otherwise.
  always @(negedge clk_sc) begin
    ev_t e;
    e = '0;
    if (!resetn) begin
      m_data  = '0;
      m_nbits = '0;
      m_par   = 1'b0;
    end else if (ev.exists(cyc)) begin
      e = ev[cyc];
    end
    if (e.valid) begin
      m_data  = e.data;
      m_nbits = e.nbits;
      m_par   = e.par;
    end
    chk("valid", 32'(rx_valid), 32'(e.valid));
    chk("sof", 32'(rx_sof), 32'(e.sof));
    chk("eof", 32'(rx_eof), 32'(e.eof));
    chk("err", 32'(rx_err), 32'(e.err));
    chk("data", 32'(rx_data), 32'(m_data));
    chk("nbits", 32'(rx_nbits), 32'(m_nbits));
    chk("par_err", 32'(rx_par_err), 32'(m_par));
    chk("busy", 32'(rx_busy), 32'(resetn && cyc >= busy_lo && cyc < busy_hi));
  end

  always @(negedge clk_sc) begin
    if (rx_sof) sof_cyc = cyc;
    if (rx_eof) eof_cyc = cyc;
    if (rx_valid) begin
      cap_d.push_back(rx_data);
      cap_n.push_back(rx_nbits);
      cap_p.push_back(rx_par_err);
      cap_c.push_back(cyc);
    end
  end

  task automatic clear_cap();
    sof_cyc = -1;
    eof_cyc = -1;
    cap_d.delete();
    cap_n.delete();
    cap_p.delete();
    cap_c.delete();
  endtask

  task automatic push_bits(input logic [7:0] b, input int nb);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < nb; i++) fb.push_back(v[i]);
  endtask

  // kind: 0 normal, 1 Z after a 1 at bit pos, 2 double-low pause at bit pos, 3 empty frame,
  // 4 rx_en dropped during bit pos, 5 reset pulsed during bit pos.
  task automatic run_frame(input int kind, input int pos);
    int         sym[$];
    bit         prev;
    int         n, c, t0, a, endc, cut, r, tc, st, w;
    logic [7:0] d;
    bit         x;
    ev_t        e;
    n = fb.size();
    prev = 1'b0;
    sym.push_back(SZ);
    if (kind == 3) begin
      sym.push_back(SY);
    end else begin
      for (int i = 0; i < n; i++) begin
        if ((kind == 1 || kind == 2) && i == pos) begin
          sym.push_back(kind == 1 ? SZ : SB);
          break;
        end
        sym.push_back(fb[i] ? SX : (prev ? SY : SZ));
        prev = fb[i];
      end
      if (kind == 0 || kind >= 4) begin
        sym.push_back(prev ? SY : SZ);
        sym.push_back(SY);
      end
    end

    c  = cyc;
    t0 = c + 3;
    a  = (pos + 1) * BC + 60;
    ev.delete();
    case (kind)
      0:       endc = t0 + (n + 3) * BC;
      1, 2:    endc = t0 + (pos + 2) * BC;
      3:       endc = t0 + 2 * BC;
      4:       endc = c + a + 1;
      default: endc = c + a;
    endcase
    cut = (kind == 0) ? endc + 1 : endc;
    busy_lo = t0;
    busy_hi = endc;

    e = '0;
    e.sof = 1'b1;
    if (t0 + BC < cut) add_ev(t0 + BC, e);
    for (int j = 0; j < n / 9; j++) begin
      x = 1'b0;
      d = '0;
      for (int i = 0; i < 9; i++) x ^= fb[9 * j + i];
      for (int i = 0; i < 8; i++) d[i] = fb[9 * j + i];
      tc = t0 + (9 * j + 11) * BC;
      e = '0;
      e.valid = 1'b1;
      e.data  = d;
      e.nbits = 4'd8;
      e.par   = (x != PAR_ODD);
      if (tc < cut) add_ev(tc, e);
    end
    e = '0;
    if (kind == 0) begin
      e.eof = 1'b1;
      r = n % 9;
      if (r > 0) begin
        d = '0;
        for (int i = 0; i < r; i++) d[i] = fb[n - r + i];
        e.valid = 1'b1;
        e.data  = d;
        e.nbits = 4'(r);
      end
      add_ev(endc, e);
    end else if (kind <= 3) begin
      e.err = 1'b1;
      add_ev(endc, e);
    end

    st = 0;
    w  = 0;
    for (int o = 0; o < sym.size() * BC + 160; o++) begin
      int s, off;
      bit low;
      s   = o / BC;
      off = o % BC;
      low = 1'b0;
      if (s < sym.size() && !((kind == 4 || kind == 5) && o >= a)) begin
        if (off == 0) begin
          if (sym[s] == SZ) begin
            st = (s == 0) ? 0 : int'($urandom_range(20, 0));
            w  = int'($urandom_range(60, 34));
          end else begin
            st = int'($urandom_range(70, 60));
            w  = int'($urandom_range(57, 40));
          end
        end
        case (sym[s])
          SZ, SX:  low = (off >= st) && (off < st + w);
          SB:      low = (off >= 10) && (off < 110);
          default: low = 1'b0;
        endcase
      end
      miller_in = ~low;
      if (kind == 4 && o == a) rx_en = 1'b0;
      if (kind == 5 && o == a) begin
        resetn = 1'b0;
        #1;
        chk("rst_data", 32'(rx_data), 32'h0);
        chk("rst_nbits", 32'(rx_nbits), 32'h0);
        chk("rst_valid", 32'(rx_valid), 32'h0);
        chk("rst_par", 32'(rx_par_err), 32'h0);
        chk("rst_sof", 32'(rx_sof), 32'h0);
        chk("rst_eof", 32'(rx_eof), 32'h0);
        chk("rst_err", 32'(rx_err), 32'h0);
        chk("rst_busy", 32'(rx_busy), 32'h0);
      end
      if (kind == 5 && o == a + 3) resetn = 1'b1;
      @(posedge clk_sc);
      #1;
    end
    miller_in = 1'b1;
    rx_en     = 1'b1;
    resetn    = 1'b1;
  endtask

  task automatic glitch(input int w);
    int c;
    ev.delete();
    c = cyc;
    busy_lo = c + 3;
    busy_hi = c + 3 + BC;
    for (int o = 0; o < 300; o++) begin
      miller_in = (o < w) ? 1'b0 : 1'b1;
      @(posedge clk_sc);
      #1;
    end
  endtask

  task automatic reqa_check(input string tag);
    chk({tag, "_count"}, 32'(cap_d.size()), 32'd1);
    chk({tag, "_data"}, (cap_d.size() > 0) ? 32'(cap_d[0]) : 32'hFFFF, 32'h26);
    chk({tag, "_nbits"}, (cap_n.size() > 0) ? 32'(cap_n[0]) : 32'hFFFF, 32'd7);
    chk({tag, "_par"}, (cap_p.size() > 0) ? 32'(cap_p[0]) : 32'hFFFF, 32'd0);
    chk({tag, "_sof_to_eof"}, 32'(eof_cyc - sof_cyc), 32'(9 * BC));
    chk({tag, "_eof_with_valid"}, 32'(eof_cyc), (cap_c.size() > 0) ? 32'(cap_c[0]) : 32'hFFFF);
  endtask

  task automatic sel_check(input string tag, input logic p);
    chk({tag, "_count"}, 32'(cap_d.size()), 32'd2);
    chk({tag, "_d0"}, (cap_d.size() > 1) ? 32'(cap_d[0]) : 32'hFFFF, 32'h93);
    chk({tag, "_d1"}, (cap_d.size() > 1) ? 32'(cap_d[1]) : 32'hFFFF, 32'h20);
    chk({tag, "_n1"}, (cap_n.size() > 1) ? 32'(cap_n[1]) : 32'hFFFF, 32'd8);
    chk({tag, "_p0"}, (cap_p.size() > 1) ? 32'(cap_p[0]) : 32'hFFFF, 32'(p));
    chk({tag, "_p1"}, (cap_p.size() > 1) ? 32'(cap_p[1]) : 32'hFFFF, 32'(p));
    chk({tag, "_eof_seen"}, 32'(eof_cyc - sof_cyc), 32'(20 * BC));
  endtask

  initial begin
    int n, kind, pos;
    clear_cap();
    repeat (4) @(posedge clk_sc);
    #1;
    chk("reset_data", 32'(rx_data), 32'h0);
    chk("reset_busy", 32'(rx_busy), 32'h0);
    resetn = 1'b1;
    rx_en  = 1'b1;
    repeat (10) @(posedge clk_sc);
    #1;

    fb.delete();
    push_bits(8'h26, 7);
    clear_cap();
    run_frame(0, 0);
    reqa_check("reqa");

    fb.delete();
    push_bits(8'h93, 8);
    fb.push_back(1'b1);
    push_bits(8'h20, 8);
    fb.push_back(1'b0);
    clear_cap();
    run_frame(0, 0);
    sel_check("sel", 1'b0);

    fb[8]  = 1'b0;
    fb[17] = 1'b1;
    clear_cap();
    run_frame(0, 0);
    sel_check("sel_badpar", 1'b1);

    fb.delete();
    for (int i = 0; i < 15; i++) fb.push_back(bit'($urandom_range(1, 0)));
    fb[5] = 1'b1;
    run_frame(1, 6);
    run_frame(2, 3);
    run_frame(2, 12);
    run_frame(3, 0);
    fb.delete();
    push_bits(8'h26, 7);
    run_frame(0, 0);

    glitch(1);
    glitch(20);

    fb.delete();
    for (int i = 0; i < 12; i++) fb.push_back(bit'($urandom_range(1, 0)));
    run_frame(4, 4);
    run_frame(5, 5);
    fb.delete();
    push_bits(8'h26, 7);
    clear_cap();
    run_frame(0, 0);
    reqa_check("reqa_after_rst");

    for (int f = 0; f < 8; f++) begin
      fb.delete();
      n = int'($urandom_range(20, 1));
      for (int i = 0; i < n; i++) fb.push_back(bit'($urandom_range(1, 0)));
      kind = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
      if (n < 2) kind = 0;
      pos = (kind != 0) ? int'($urandom_range(n - 1, 1)) : 0;
      if (kind == 1) fb[pos - 1] = 1'b1;
      run_frame(kind, pos);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
